// File: rtl/kmeans_feeder_if.sv
// Bundle of the feeder's job-control, stream and result-capture signals.
// Handshake: out_valid marks a stream word for the accelerator (no backpressure); res_valid marks one result word from it.
interface kmeans_feeder_if;
  logic        start;
  logic [15:0] seed;
  logic        out_valid;
  logic [15:0] out_data;
  logic        res_valid;
  logic [15:0] res_data;
  logic        busy;
  logic        done;
  logic [15:0] res0;
  logic [15:0] res1;
  logic [15:0] res2;
  logic [15:0] res3;
  logic        timeout_err;
  logic        protocol_err;
  logic [2:0]  state_dbg;

  modport slave (
    input  start, seed, res_valid, res_data,
    output out_valid, out_data, busy, done, res0, res1, res2, res3,
           timeout_err, protocol_err, state_dbg
  );

  modport master (
    output start, seed, res_valid, res_data,
    input  out_valid, out_data, busy, done, res0, res1, res2, res3,
           timeout_err, protocol_err, state_dbg
  );
endinterface

// File: rtl/kmeans_feeder.sv
// Streams LFSR-generated centroids and data points to a k-means accelerator,
// then collects the four result centroids with timeout and burst-shape checks.
module kmeans_feeder #(
  parameter int unsigned DATA_SIZE      = 4096,
  parameter int unsigned CLUSTER_SIZE   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 24'hFFFFFF
) (
  input logic            clk,
  input logic            rst_n,
  kmeans_feeder_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SEND     = 3'd1,
    WAIT_RES = 3'd2,
    COLLECT  = 3'd3,
    DONE     = 3'd4
  } state_t;

  localparam logic [12:0] SEND_LAST = 13'(CLUSTER_SIZE + DATA_SIZE - 1);
  localparam logic [23:0] TO_LAST   = 24'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [12:0] cnt_q, cnt_d;
  logic [23:0] timer_q, timer_d;
  logic [1:0]  col_q, col_d;
  logic        out_valid_q, out_valid_d;
  logic [15:0] out_data_q, out_data_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [15:0] res_q [0:3];
  logic [15:0] res_d [0:3];
  logic        timeout_q, timeout_d;
  logic        proto_q, proto_d;

  function automatic logic [15:0] lfsr_step(input logic [15:0] x);
    return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
  endfunction

  // out_data doubles as the LFSR state while streaming.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    timer_d     = timer_q;
    col_d       = col_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    res_d       = res_q;
    timeout_d   = timeout_q;
    proto_d     = proto_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d     = SEND;
          out_valid_d = 1'b1;
          out_data_d  = (bus.seed == 16'h0000) ? 16'hACE1 : bus.seed;
          busy_d      = 1'b1;
          cnt_d       = '0;
          for (int i = 0; i < 4; i++) res_d[i] = '0;
          timeout_d   = 1'b0;
          proto_d     = 1'b0;
        end
      end
      SEND: begin
        if (bus.res_valid) proto_d = 1'b1;
        if (cnt_q == SEND_LAST) begin
          out_valid_d = 1'b0;
          out_data_d  = '0;
          timer_d     = '0;
          state_d     = WAIT_RES;
        end else begin
          cnt_d      = cnt_q + 13'd1;
          out_data_d = lfsr_step(out_data_q);
        end
      end
      WAIT_RES: begin
        if (bus.res_valid) begin
          res_d[0] = bus.res_data;
          timer_d  = '0;
          col_d    = '0;
          state_d  = COLLECT;
        end else if (timer_q == TO_LAST) begin
          timeout_d = 1'b1;
          done_d    = 1'b1;
          state_d   = DONE;
        end else begin
          timer_d = timer_q + 24'd1;
        end
      end
      COLLECT: begin
        if (bus.res_valid) begin
          res_d[col_q + 2'd1] = bus.res_data;
          if (col_q == 2'd2) begin
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            col_d = col_q + 2'd1;
          end
        end else begin
          proto_d = 1'b1;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      timer_q     <= '0;
      col_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      for (int i = 0; i < 4; i++) res_q[i] <= '0;
      timeout_q   <= 1'b0;
      proto_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      timer_q     <= timer_d;
      col_q       <= col_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      for (int i = 0; i < 4; i++) res_q[i] <= res_d[i];
      timeout_q   <= timeout_d;
      proto_q     <= proto_d;
    end
  end

  assign bus.out_valid    = out_valid_q;
  assign bus.out_data     = out_data_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.res0         = res_q[0];
  assign bus.res1         = res_q[1];
  assign bus.res2         = res_q[2];
  assign bus.res3         = res_q[3];
  assign bus.timeout_err  = timeout_q;
  assign bus.protocol_err = proto_q;
  assign bus.state_dbg    = state_q;

endmodule

// File: tb/tb_kmeans_feeder.sv
// Directed bench for kmeans_feeder: streams, result bursts, timeout,
// short bursts, ignored inputs and mid-job reset.
module tb_kmeans_feeder;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  kmeans_feeder_if bus ();

  kmeans_feeder #(
    .DATA_SIZE      (4096),
    .CLUSTER_SIZE   (4),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model_step(input logic [15:0] x);
    logic fb;
    fb = x[15] ^ x[13] ^ x[12] ^ x[10];
    return {x[14:0], fb};
  endfunction

  // driver tasks
  task automatic start_job(input logic [15:0] s);
    bus.seed  = s;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // Checks n consecutive words from first; at index poke, pulses res_valid and
  // a foreign start, both of which must leave the stream untouched.
  task automatic check_stream(input logic [15:0] first, input int n, input int poke);
    logic [15:0] m;
    m = first;
    for (int k = 0; k < n; k++) begin
      bus.res_valid = (k == poke);
      bus.res_data  = 16'hDEAD;
      bus.start     = (k == poke);
      bus.seed      = 16'h7777;
      chk("stream_valid", {15'd0, bus.out_valid}, 16'd1);
      chk("stream_word", bus.out_data, m);
      if (k == 0 || k == n - 1) chk("stream_busy", {15'd0, bus.busy}, 16'd1);
      m = model_step(m);
      tick();
    end
    bus.res_valid = 1'b0;
    bus.start     = 1'b0;
    bus.res_data  = 16'h0000;
  endtask

  task automatic send_res(input logic [15:0] d);
    bus.res_valid = 1'b1;
    bus.res_data  = d;
    tick();
    bus.res_valid = 1'b0;
    bus.res_data  = 16'h0000;
  endtask

  task automatic check_results(input logic [15:0] e0, input logic [15:0] e1,
                               input logic [15:0] e2, input logic [15:0] e3,
                               input logic et, input logic ep);
    chk("res0", bus.res0, e0);
    chk("res1", bus.res1, e1);
    chk("res2", bus.res2, e2);
    chk("res3", bus.res3, e3);
    chk("timeout_err", {15'd0, bus.timeout_err}, {15'd0, et});
    chk("protocol_err", {15'd0, bus.protocol_err}, {15'd0, ep});
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.seed      = 16'h0000;
    bus.res_valid = 1'b0;
    bus.res_data  = 16'h0000;
    tick();
    tick();

    // reset state
    chk("rst_out_valid", {15'd0, bus.out_valid}, 16'd0);
    chk("rst_out_data", bus.out_data, 16'h0000);
    chk("rst_busy", {15'd0, bus.busy}, 16'd0);
    chk("rst_done", {15'd0, bus.done}, 16'd0);
    check_results(16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();

    // seed 1: hand-checked opening words, full stream, then clean 4-word burst
    start_job(16'h0001);
    chk("seed1_w0", bus.out_data, 16'h0001);
    check_stream(16'h0001, 4100, -1);
    chk("end_valid", {15'd0, bus.out_valid}, 16'd0);
    chk("end_data", bus.out_data, 16'h0000);
    chk("end_busy", {15'd0, bus.busy}, 16'd1);
    send_res(16'h1020);
    send_res(16'h3040);
    send_res(16'h5060);
    chk("no_early_done", {15'd0, bus.done}, 16'd0);
    send_res(16'h7080);
    chk("burst_done", {15'd0, bus.done}, 16'd1);
    chk("burst_busy", {15'd0, bus.busy}, 16'd1);
    check_results(16'h1020, 16'h3040, 16'h5060, 16'h7080, 1'b0, 1'b0);
    tick();
    chk("burst_done_off", {15'd0, bus.done}, 16'd0);
    chk("burst_busy_off", {15'd0, bus.busy}, 16'd0);

    // seed 0 -> ACE1; res_valid and start poked mid-stream; then timeout
    tick();
    start_job(16'h0000);
    chk("seed0_cleared", bus.res0, 16'h0000);
    chk("seed0_w0", bus.out_data, 16'hACE1);
    check_stream(16'hACE1, 1, -1);
    chk("seed0_w1", bus.out_data, 16'h59C3);
    check_stream(16'h59C3, 4099, 1000);
    for (int i = 0; i < 99; i++) tick();
    chk("to_not_yet", {15'd0, bus.done}, 16'd0);
    tick();
    chk("to_done", {15'd0, bus.done}, 16'd1);
    check_results(16'h0, 16'h0, 16'h0, 16'h0, 1'b1, 1'b1);
    tick();
    chk("to_done_off", {15'd0, bus.done}, 16'd0);
    chk("to_sticky", {15'd0, bus.timeout_err}, 16'd1);

    // short burst: errors cleared by start, two words kept, protocol_err
    start_job(16'h1234);
    chk("clr_timeout", {15'd0, bus.timeout_err}, 16'd0);
    chk("clr_protocol", {15'd0, bus.protocol_err}, 16'd0);
    check_stream(16'h1234, 4100, -1);
    send_res(16'hAAAA);
    send_res(16'hBBBB);
    tick();
    chk("short_done", {15'd0, bus.done}, 16'd1);
    check_results(16'hAAAA, 16'hBBBB, 16'h0000, 16'h0000, 1'b0, 1'b1);
    tick();
    // res_valid in IDLE is ignored
    send_res(16'h5555);
    send_res(16'h6666);
    chk("idle_res_done", {15'd0, bus.done}, 16'd0);
    check_results(16'hAAAA, 16'hBBBB, 16'h0000, 16'h0000, 1'b0, 1'b1);

    // reset at word 2000 aborts without done, then a fresh job from seed 1
    start_job(16'h0001);
    check_stream(16'h0001, 2000, -1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("abort_valid", {15'd0, bus.out_valid}, 16'd0);
    chk("abort_busy", {15'd0, bus.busy}, 16'd0);
    chk("abort_done", {15'd0, bus.done}, 16'd0);
    check_results(16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort_no_done", {15'd0, bus.done}, 16'd0);
      chk("abort_no_valid", {15'd0, bus.out_valid}, 16'd0);
    end
    start_job(16'h0001);
    check_stream(16'h0001, 4100, -1);
    chk("rerun_end_valid", {15'd0, bus.out_valid}, 16'd0);
    send_res(16'h0102);
    send_res(16'h0304);
    send_res(16'h0506);
    send_res(16'h0708);
    chk("rerun_done", {15'd0, bus.done}, 16'd1);
    check_results(16'h0102, 16'h0304, 16'h0506, 16'h0708, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/kmeans_feeder.md
KMEANS_FEEDER -- requirements
Module: kmeans_feeder

Interface
REQ-001 Parameter DATA_SIZE, 4096, number of data points sent after the centroids.
REQ-002 Parameter CLUSTER_SIZE, 4, number of initial centroids sent and result words collected.
REQ-003 Parameter TIMEOUT_CYCLES, 24'hFFFFFF, maximum number of WAIT_RES cycles before abort.
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 start  input  1  request one job; sampled only in IDLE.
REQ-007 seed  input  16  LFSR seed; captured on start acceptance.
REQ-008 out_valid  output  1  stream valid to accelerator in_valid.
REQ-009 out_data  output  16  stream word {x[15:8], y[7:0]} to accelerator in_data.
REQ-010 res_valid  input  1  accelerator out_valid.
REQ-011 res_data  input  16  accelerator out_data (centroid).
REQ-012 busy  output  1  high from the cycle after start acceptance until the cycle that done pulses, inclusive.
REQ-013 done  output  1  one-cycle pulse at job end (success or error).
REQ-014 res0, res1, res2, res3  output  16 each  captured centroids.
REQ-015 timeout_err  output  1  sticky job error: no result within TIMEOUT_CYCLES.
REQ-016 protocol_err  output  1  sticky job error: malformed result burst.

Function
REQ-017 The FSM SHALL have states IDLE, SEND, WAIT_RES, COLLECT and DONE; all outputs SHALL be registered.
REQ-018 IDLE: start=1 SHALL load the LFSR with seed (16'hACE1 if seed==0), clear res0-3 and both error flags, and enter SEND; start in any other state SHALL be ignored.
REQ-019 SEND: out_valid SHALL be 1 for exactly CLUSTER_SIZE+DATA_SIZE (4100) consecutive cycles, beginning the cycle after start acceptance, with no gaps.
REQ-020 Word k (k=0..4099) SHALL be the LFSR state after k steps; word 0 SHALL equal the loaded seed.
REQ-021 LFSR step: shift left by one; bit0 SHALL become b15^b13^b12^b10 (maximal length, period 65535).
REQ-022 Words 0-3 SHALL be the initial centroids and words 4-4099 the data points; the 13-bit send counter SHALL not wrap inside a job.
REQ-023 The cycle after word 4099, out_valid and out_data SHALL return to 0 and the FSM SHALL enter WAIT_RES; out_data SHALL be 0 whenever out_valid=0.
REQ-024 WAIT_RES: a 24-bit timer SHALL count from 0; res_valid=1 SHALL capture res_data into res0, reset the timer and enter COLLECT.
REQ-025 If the timer reaches TIMEOUT_CYCLES-1 without res_valid, the FSM SHALL set timeout_err and enter DONE.
REQ-026 COLLECT: the next three consecutive res_valid cycles SHALL store res_data into res1, res2 and res3 in order, then enter DONE.
REQ-027 res_valid=0 in COLLECT before res3 is stored SHALL set protocol_err and enter DONE, keeping the words already stored.
REQ-028 res_valid=1 during SEND SHALL set protocol_err; the stream SHALL complete unaffected.
REQ-029 DONE SHALL last one cycle, pulse done, drop busy the following cycle and return to IDLE.
REQ-030 res_valid in IDLE or DONE SHALL be ignored.
REQ-031 res0-3 and both error flags SHALL hold their values until the next start is accepted.

Reset
REQ-032 When rst_n=0 at a clock edge, the FSM SHALL go to IDLE and out_valid, out_data, busy, done, res0-3, timeout_err and protocol_err SHALL be 0 from the next cycle.
REQ-033 Reset asserted mid-SEND or mid-COLLECT SHALL abort the job immediately, with no done pulse.
REQ-034 After reset the first accepted start SHALL behave identically to a start after power-up.

Verification
REQ-035 seed=16'h0001, start -> out_valid high 4100 cycles; words 0x0001, 0x0002, 0x0004, 0x0008...; out_valid=0 in cycle 4101.
REQ-036 seed=0 -> word 0 = 0xACE1; word 1 = 0x59C3.
REQ-037 SEND complete, res_valid burst of four words 0x1020, 0x3040, 0x5060, 0x7080 -> res0-3 hold these values, done pulses one cycle after 0x7080, errors 0.
REQ-038 TIMEOUT_CYCLES=100, no res_valid -> timeout_err=1 and done 100 cycles after WAIT_RES entry; next start clears timeout_err.
REQ-039 Burst of only two words 0xAAAA, 0xBBBB -> res0=0xAAAA, res1=0xBBBB, res2=res3=0, protocol_err=1, done pulses.
REQ-040 rst_n=0 at word 2000 -> out_valid=0 next cycle, no done pulse; start with seed=1 -> full 4100-word stream from 0x0001.
